// File: rtl/reg_file_sequencer_if.sv
// Requester-side handshake and register file strobe bundle for reg_file_sequencer.
// master: requester/bench side (drives req/op/idx/data); slave: the sequencer.
interface reg_file_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          req0;
    logic          req1;
    logic          op0;
    logic          op1;
    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          done0;
    logic          done1;
    logic          busy;
    logic          SETSRC;
    logic          SETDEST;
    logic          REGWRITE;
    logic [AW-1:0] rt_index;
    logic [DW-1:0] write_value;

    modport master (
        output req0, req1, op0, op1, idx0, idx1, data0, data1,
        input  done0, done1, busy, SETSRC, SETDEST, REGWRITE,
        input  rt_index, write_value
    );

    modport slave (
        input  req0, req1, op0, op1, idx0, idx1, data0, data1,
        output done0, done1, busy, SETSRC, SETDEST, REGWRITE,
        output rt_index, write_value
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// Two-requester round-robin sequencer expanding atomic register operations
// into SETDEST/REGWRITE/SETSRC strobes, skipping strobes whose pointer is cached.
// Ports: CLK, RESET (async, active-high), bus (slave modport of the interface).
module reg_file_sequencer #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    reg_file_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETD,
        S_WR,
        S_SETS,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_op;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_data;
    logic          r_owner;
    logic          r_prio;
    logic [AW-1:0] r_src_idx;
    logic          r_src_valid;
    logic [AW-1:0] r_dst_idx;
    logic          r_dst_valid;
    logic          r_setsrc;
    logic          r_setdest;
    logic          r_regwrite;
    logic [AW-1:0] r_rt_index;
    logic [DW-1:0] r_write_value;
    logic          r_done0;
    logic          r_done1;
    logic          r_busy;

    // Requester 1 wins when alone, or when both ask and it holds priority.
    logic          w_any;
    logic          w_gnt1;
    logic          w_op;
    logic [AW-1:0] w_idx;
    logic [DW-1:0] w_data;
    logic          w_dhit;
    logic          w_shit;

    assign w_any  = bus.req0 | bus.req1;
    assign w_gnt1 = bus.req1 & (~bus.req0 | r_prio);
    assign w_op   = w_gnt1 ? bus.op1   : bus.op0;
    assign w_idx  = w_gnt1 ? bus.idx1  : bus.idx0;
    assign w_data = w_gnt1 ? bus.data1 : bus.data0;
    assign w_dhit = r_dst_valid & (r_dst_idx == w_idx);
    assign w_shit = r_src_valid & (r_src_idx == w_idx);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_op          <= 1'b0;
            r_idx         <= '0;
            r_data        <= '0;
            r_owner       <= 1'b0;
            r_prio        <= 1'b0;
            r_src_idx     <= '0;
            r_src_valid   <= 1'b0;
            r_dst_idx     <= '0;
            r_dst_valid   <= 1'b0;
            r_setsrc      <= 1'b0;
            r_setdest     <= 1'b0;
            r_regwrite    <= 1'b0;
            r_rt_index    <= '0;
            r_write_value <= '0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // Registered outputs default low; each state sets what the next one shows.
            r_setsrc      <= 1'b0;
            r_setdest     <= 1'b0;
            r_regwrite    <= 1'b0;
            r_rt_index    <= '0;
            r_write_value <= '0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op    <= w_op;
                        r_idx   <= w_idx;
                        r_data  <= w_data;
                        r_owner <= w_gnt1;
                        r_busy  <= 1'b1;
                        if (!w_op && !w_dhit) begin
                            r_state    <= S_SETD;
                            r_setdest  <= 1'b1;
                            r_rt_index <= w_idx;
                        end else if (!w_op) begin
                            r_state       <= S_WR;
                            r_regwrite    <= 1'b1;
                            r_rt_index    <= w_idx;
                            r_write_value <= w_data;
                        end else if (!w_shit) begin
                            r_state    <= S_SETS;
                            r_setsrc   <= 1'b1;
                            r_rt_index <= w_idx;
                        end else begin
                            r_state <= S_DONE;
                            r_done0 <= ~w_gnt1;
                            r_done1 <= w_gnt1;
                        end
                    end
                end
                S_SETD: begin
                    r_dst_idx     <= r_idx;
                    r_dst_valid   <= 1'b1;
                    r_state       <= S_WR;
                    r_regwrite    <= 1'b1;
                    r_rt_index    <= r_idx;
                    r_write_value <= r_data;
                end
                S_WR: begin
                    r_state <= S_DONE;
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                end
                S_SETS: begin
                    r_src_idx   <= r_idx;
                    r_src_valid <= 1'b1;
                    r_state     <= S_DONE;
                    r_done0     <= ~r_owner;
                    r_done1     <= r_owner;
                end
                S_DONE: begin
                    r_prio  <= ~r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.SETSRC      = r_setsrc;
    assign bus.SETDEST     = r_setdest;
    assign bus.REGWRITE    = r_regwrite;
    assign bus.rt_index    = r_rt_index;
    assign bus.write_value = r_write_value;
    assign bus.done0       = r_done0;
    assign bus.done1       = r_done1;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: transaction-level model, directed cases, random traffic.
// Instantiates the interface and drives it from the master side.
module tb_reg_file_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_sequencer_if #(.DW(8), .AW(3)) bus ();

    reg_file_sequencer #(.DW(8), .AW(3)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ss;
        logic       sd;
        logic       rw;
        logic       d0;
        logic       d1;
        logic       busy;
        logic [2:0] ri;
        logic [7:0] wv;
    } exp_t;

    function automatic exp_t snap();
        exp_t s;
        s.ss   = bus.SETSRC;
        s.sd   = bus.SETDEST;
        s.rw   = bus.REGWRITE;
        s.d0   = bus.done0;
        s.d1   = bus.done1;
        s.busy = bus.busy;
        s.ri   = bus.rt_index;
        s.wv   = bus.write_value;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Emulated register file fed by the strobes.
    logic [7:0] rf [8];
    logic [2:0] rf_dptr = '0;
    always @(posedge clk) begin
        if (bus.SETDEST) rf_dptr <= bus.rt_index;
        if (bus.REGWRITE) rf[rf_dptr] <= bus.write_value;
    end

    // Transaction model: on accept, queue the whole expected output sequence.
    exp_t q[$];
    exp_t cur = '0;
    bit   m_prio = 1'b0;
    bit   m_sv = 1'b0;
    bit   m_dv = 1'b0;
    logic [2:0] m_si = '0;
    logic [2:0] m_di = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            cur = '0;
            m_prio = 1'b0;
            m_sv = 1'b0;
            m_dv = 1'b0;
        end else begin
            if (!cur.busy && (bus.req0 || bus.req1)) begin
                bit own;
                bit op;
                logic [2:0] idx;
                logic [7:0] d;
                exp_t e;
                own = (bus.req0 && bus.req1) ? m_prio : bus.req1;
                op  = own ? bus.op1 : bus.op0;
                idx = own ? bus.idx1 : bus.idx0;
                d   = own ? bus.data1 : bus.data0;
                if (!op) begin
                    if (!(m_dv && m_di == idx)) begin
                        e = '0; e.busy = 1; e.sd = 1; e.ri = idx;
                        q.push_back(e);
                        m_dv = 1; m_di = idx;
                    end
                    e = '0; e.busy = 1; e.rw = 1; e.ri = idx; e.wv = d;
                    q.push_back(e);
                end else if (!(m_sv && m_si == idx)) begin
                    e = '0; e.busy = 1; e.ss = 1; e.ri = idx;
                    q.push_back(e);
                    m_sv = 1; m_si = idx;
                end
                e = '0; e.busy = 1; e.d0 = !own; e.d1 = own;
                q.push_back(e);
                m_prio = !own;
            end
            cur = (q.size() != 0) ? q.pop_front() : '0;
        end
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if (snap() !== cur) begin
            errors++;
            $display("FAIL cycle t=%0t dut=%h model=%h", $time, snap(), cur);
        end
    end

    task automatic set_req(input int r, input logic v, input logic op,
                           input logic [2:0] idx, input logic [7:0] d);
        if (r == 0) begin
            bus.req0 = v; bus.op0 = op; bus.idx0 = idx; bus.data0 = d;
        end else begin
            bus.req1 = v; bus.op1 = op; bus.idx1 = idx; bus.data1 = d;
        end
    endtask

    exp_t t[16];
    int   t_n;

    // Trace cycles from the idle cycle before accept until all pending dones.
    task automatic record(input bit p0, input bit p1, input bit drop0);
        bit a0;
        bit a1;
        a0 = p0; a1 = p1; t_n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            t[i] = snap();
            t_n = i + 1;
            @(posedge clk); #2;
            if (t[i].d0) begin bus.req0 = 0; a0 = 0; end
            if (t[i].d1) begin bus.req1 = 0; a1 = 0; end
            if (drop0 && i == 0) bus.req0 = 0;
            if (!a0 && !a1) break;
        end
        if (a0 || a1) begin
            errors++;
            $display("FAIL record-timeout pending %0d%0d expected 00", a0, a1);
            bus.req0 = 0; bus.req1 = 0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1; #1; rst = 0;
    endtask

    task automatic requester(input int r, input int n);
        for (int k = 0; k < n; k++) begin
            bit got;
            got = 0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
            set_req(r, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 8'($urandom));
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if ((r == 0) ? bus.done0 : bus.done1) begin got = 1; break; end
                @(posedge clk); #2;
                set_req(r, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 8'($urandom));
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL req%0d-timeout done got 0 expected 1", r);
            end
            @(posedge clk); #2;
            set_req(r, 0, 0, 0, 0);
        end
    endtask

    initial begin
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        #3;
        chk("reset-busy", bus.busy, 0);
        chk("reset-strobes", {bus.SETSRC, bus.SETDEST, bus.REGWRITE}, 0);
        chk("reset-done", {bus.done0, bus.done1}, 0);
        repeat (2) @(posedge clk);
        #2; rst = 0;

        // Write 26 to r5, cold caches.
        set_req(0, 1, 0, 5, 26);
        record(1, 0, 0);
        chk("A-len", t_n, 4);
        chk("A-setd", {t[1].sd, t[1].rw, t[1].ri}, {1'b1, 1'b0, 3'd5});
        chk("A-wr", {t[2].rw, t[2].sd, t[2].wv}, {1'b1, 1'b0, 8'd26});
        chk("A-done", {t[3].d0, t[3].d1}, 2'b10);
        chk("A-rf5", rf[5], 26);

        // Same register again: dest-cache hit.
        set_req(0, 1, 0, 5, 7);
        record(1, 0, 0);
        chk("B-len", t_n, 3);
        chk("B-wr", {t[1].sd, t[1].rw, t[1].wv}, {1'b0, 1'b1, 8'd7});
        chk("B-done", t[2].d0, 1);
        chk("B-rf5", rf[5], 7);

        // Both requesters together after reset.
        pulse_reset();
        set_req(0, 1, 0, 2, 11);
        set_req(1, 1, 0, 3, 22);
        record(1, 1, 0);
        chk("C-len", t_n, 8);
        chk("C-first", {t[1].sd, t[1].ri, t[2].wv}, {1'b1, 3'd2, 8'd11});
        chk("C-done0", t[3].d0, 1);
        chk("C-gap", t[4].busy, 0);
        chk("C-second", {t[5].sd, t[5].ri, t[6].wv}, {1'b1, 3'd3, 8'd22});
        chk("C-done1", t[7].d1, 1);

        // req0 alone hands priority to req1 for the next collision.
        set_req(0, 1, 0, 2, 33);
        record(1, 0, 0);
        chk("D1-len", t_n, 4);
        set_req(0, 1, 0, 2, 55);
        set_req(1, 1, 0, 3, 44);
        record(1, 1, 0);
        chk("D2-len", t_n, 8);
        chk("D2-first", {t[1].ri, t[2].wv, t[3].d1}, {3'd3, 8'd44, 1'b1});
        chk("D2-second", {t[5].sd, t[5].ri, t[6].wv, t[7].d0}, {1'b1, 3'd2, 8'd55, 1'b1});

        // Set source to 6 twice.
        set_req(1, 1, 1, 6, 8'hff);
        record(0, 1, 0);
        chk("E1-len", t_n, 3);
        chk("E1-sets", {t[1].ss, t[1].ri}, {1'b1, 3'd6});
        chk("E1-done", t[2].d1, 1);
        set_req(1, 1, 1, 6, 0);
        record(0, 1, 0);
        chk("E2-len", t_n, 2);
        chk("E2-hit", {t[1].ss, t[1].d1}, 2'b01);

        // Reset in the middle of WR.
        set_req(0, 1, 0, 4, 9);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("F-inwr", {bus.REGWRITE, bus.busy}, 2'b11);
        rst = 1;
        #1;
        chk("F-abort", {bus.REGWRITE, bus.busy, bus.done0}, 0);
        set_req(0, 0, 0, 0, 0);
        #1; rst = 0;
        @(posedge clk); #2;
        set_req(0, 1, 0, 4, 9);
        record(1, 0, 0);
        chk("F-resetd", {t[1].sd, t[1].ri}, {1'b1, 3'd4});
        chk("F-len", t_n, 4);

        // req0 dropped right after accept.
        set_req(0, 1, 0, 1, 3);
        record(1, 0, 1);
        chk("G-len", t_n, 4);
        chk("G-seq", {t[1].sd, t[1].ri, t[2].wv, t[3].d0}, {1'b1, 3'd1, 8'd3, 1'b1});

        fork
            requester(0, 60);
            requester(1, 60);
        join
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_sequencer.md
# reg_file_sequencer

Control sequencer placed in front of the 8-entry, 8-bit register file. It accepts atomic register operations from two requesters, round-robin arbitrates between them, and expands each operation into the register file's pointer-set / write strobe sequence (SETDEST then REGWRITE, or SETSRC). It caches the register file's current source and destination pointers so that redundant SETSRC/SETDEST strobes are skipped.

## Interface
- DW, 8, data width; matches register file write_value.
- AW, 3, register index width; matches register file rt_index.

- CLK  in  1  clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  operation request; held high until matching done.
- op0, op1  in  1 each  0 = write register, 1 = set source pointer.
- idx0, idx1  in  AW each  target register index.
- data0, data1  in  DW each  write data; ignored for op=1.
- done0, done1  out  1 each  one-cycle completion pulse to the owning requester.
- busy  out  1  high in every state except IDLE.
- SETSRC, SETDEST, REGWRITE  out  1 each  register file strobes.
- rt_index  out  AW  register file index.
- write_value  out  DW  register file write data.

## Operation
- FSM states: IDLE, SETD, WR, SETS, DONE. Moore outputs are decoded from the registered state and the latched operation.
- IDLE: if any req is high, grant one requester and latch its op, idx and data and the owner ID.
  - op=0, dest-cache miss: go to SETD.
  - op=0, dest-cache hit: go to WR.
  - op=1, src-cache miss: go to SETS.
  - op=1, src-cache hit: go to DONE.
- SETD: SETDEST=1, rt_index=idx. Load the dest cache with idx and set dest_valid. Go to WR.
- WR: REGWRITE=1, write_value=data, rt_index=idx. Go to DONE.
- SETS: SETSRC=1, rt_index=idx. Load the src cache with idx and set src_valid. Go to DONE.
- DONE: pulse done of the owner. Priority pointer moves to the non-owner. Go to IDLE.
- Arbitration:
  - Round-robin between the two requesters.
  - After reset, requester 0 has priority.
  - A single requester is granted regardless of the pointer.
- Operations are atomic. Dropping req after grant does not abort the sequence, and done still pulses.
- At most one strobe is high in any cycle.
- Outside SETD, WR and SETS, rt_index and write_value are driven to 0.
- Inputs are sampled only at the IDLE accept edge. Later changes to op, idx or data have no effect on the operation in flight.

## Timing
- Reset (asynchronous; takes effect immediately, independent of CLK):
  - State returns to IDLE.
  - All outputs go to 0: strobes, rt_index, write_value, done0/1, busy.
  - src_valid and dest_valid are cleared.
  - Priority returns to requester 0.
- Reset during any state abandons the operation. No done is issued, and the pointer caches are invalid afterwards.
- Latency from the accepting edge k (IDLE with req high) to the done cycle:
  - Write, cache miss: SETD in cycle k..k+1, WR in k+1..k+2, done high in k+2..k+3.
  - Write, cache hit: WR in k..k+1, done high in k+1..k+2.
  - Set source, miss: SETS in k..k+1, done high in k+1..k+2.
  - Set source, hit: done high in k..k+1.
- Minimum spacing: there is always one IDLE cycle between a DONE and the next accept.
- Requester rule: req must be low in the cycle after done. A req still high in that IDLE cycle is treated as a new request.
- Both requests high at the same IDLE edge: the higher-priority requester is served. The other is accepted at the IDLE edge following that DONE.
- The caches track only operations issued by this block. No other agent may drive register file strobes.

## Test plan
- Reset, then req0 writes 26 to register 5:
  - SETDEST=1 with rt_index=5 for one cycle.
  - Next cycle: REGWRITE=1 with write_value=26.
  - Next cycle: done0=1.
  - Register file read at rt_index=5 returns 26.
- Immediately after, req0 writes 7 to register 5:
  - No SETDEST pulse.
  - REGWRITE with write_value=7 in the cycle after accept.
  - done0 one cycle later.
- req0 and req1 both assert writes (reg 2=11, reg 3=22) at the same edge after reset:
  - reg 2 sequence and done0 first.
  - One IDLE cycle.
  - Then the reg 3 sequence and done1.
  - Repeat with both high again: requester 1 is now served second only if its priority was consumed. Check the alternation.
- req1 set-source to 6: one SETSRC pulse with rt_index=6, then done1. A second set-source to 6 gives no SETSRC and done1 in the cycle after accept.
- RESET asserted during WR:
  - REGWRITE and busy drop immediately, with no done.
  - A following write to the same index re-issues SETDEST (cache cleared).
- req0 dropped the cycle after accept: the write sequence still completes and done0 pulses.
